ddr3_req_scheduler: RTL and testbench

Host-side request front end for the DDR3 command state machine. Accepts single-beat read/write requests over a valid/ready handshake and decodes the flat address into bank/row/column. It produces the level-held command strobes (ZQCL, REF, ACT, WRITE, READ) and the address/data fields the command state machine consumes. It owns power-up sequencing up to ZQ calibration and periodic refresh scheduling.

---
 rtl/ddr3_req_scheduler.sv | 155 +++++++++++++++
 tb/tb_ddr3_req_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_req_scheduler.sv
// ddr3_req_scheduler: host request front end for the DDR3 command state machine.
// Decodes flat addresses into bank/row/column, sequences power-up through ZQCL,
// schedules periodic refresh and holds ACT/WRITE/READ strobes per transaction.
// Ports:
//   CLK, RESET_N (async, active-low)
//   REQ_VALID/REQ_READY handshake with REQ_WE, REQ_AP, REQ_ADDR[27:0], REQ_WDATA[15:0]
//   ZQCL, REF, ACT, WRITE, READ strobes to the command state machine
//   Addr_Row, Addr_Column, Addr_Column_11, A_10, A_12, A13_14, BA_in, Data_input fields
//   REF_PENDING owed refresh count (0..8)
// Build option: REF_POSTPONE_EN lets requests overtake owed refreshes until 8 are owed.
module ddr3_req_scheduler #(
  parameter int INIT_CYCLES = 16,
  parameter int TXN_CYCLES  = 5,
  parameter int TREFI       = 780,
  parameter int TRFC_CYCLES = 12
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic        REQ_AP,
  input  logic [27:0] REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  output logic        ZQCL,
  output logic        REF,
  output logic        ACT,
  output logic        WRITE,
  output logic        READ,
  output logic [14:0] Addr_Row,
  output logic [9:0]  Addr_Column,
  output logic        Addr_Column_11,
  output logic        A_12,
  output logic [1:0]  A13_14,
  output logic        A_10,
  output logic [2:0]  BA_in,
  output logic [15:0] Data_input,
  output logic [3:0]  REF_PENDING
);
  typedef enum logic [2:0] {INIT_WAIT, ZQ, ZQ_WAIT, IDLE, XFER, REFRESH, REF_WAIT} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, tmr_q, tmr_d;
  logic [3:0]  pend_q, pend_d;
  logic        run_q, run_d, we_q, we_d, accept, dec, tick;
  function automatic logic must_ref(input logic [3:0] p);
`ifdef REF_POSTPONE_EN
    return p == 4'd8;
`else
    return p != 4'd0;
`endif
  endfunction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    accept  = 1'b0;
    dec     = 1'b0;
    case (state_q)
      INIT_WAIT: if (cnt_q == 16'(INIT_CYCLES)) begin
        state_d = ZQ;
        cnt_d   = '0;
      end
      ZQ: begin
        state_d = ZQ_WAIT;
        cnt_d   = '0;
      end
      ZQ_WAIT: if (cnt_q == 16'd1) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      IDLE: begin
        cnt_d = '0;
        if (must_ref(pend_q)) begin
          state_d = REFRESH;
          dec     = 1'b1;
        end else if (REQ_VALID && REQ_READY) begin
          state_d = XFER;
          accept  = 1'b1;
        end else if (pend_q != 4'd0) begin
          state_d = REFRESH;
          dec     = 1'b1;
        end
      end
      XFER: if (cnt_q == 16'(TXN_CYCLES - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      REFRESH: begin
        state_d = REF_WAIT;
        cnt_d   = '0;
      end
      REF_WAIT: if (cnt_q == 16'(TRFC_CYCLES - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = INIT_WAIT;
        cnt_d   = '0;
      end
    endcase
  end
  // The refresh timer is armed by the first IDLE cycle and never stops afterwards.
  assign run_d  = run_q | (state_q == IDLE);
  assign tick   = run_d && (tmr_q == 16'(TREFI - 1));
  assign tmr_d  = !run_d ? tmr_q : tick ? 16'd0 : tmr_q + 16'd1;
  // A tick and a served refresh in the same cycle cancel out.
  assign pend_d = (tick && !dec && pend_q != 4'd8) ? pend_q + 4'd1 :
                  (dec && !tick) ? pend_q - 4'd1 : pend_q;
  assign we_d   = accept ? REQ_WE : we_q;
  assign REF_PENDING    = pend_q;
  assign Addr_Column_11 = 1'b0;
  assign A13_14         = 2'b00;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= INIT_WAIT;
      cnt_q       <= '0;
      tmr_q       <= '0;
      pend_q      <= '0;
      run_q       <= 1'b0;
      we_q        <= 1'b0;
      REQ_READY   <= 1'b0;
      ZQCL        <= 1'b0;
      REF         <= 1'b0;
      ACT         <= 1'b0;
      WRITE       <= 1'b0;
      READ        <= 1'b0;
      A_12        <= 1'b0;
      A_10        <= 1'b0;
      BA_in       <= '0;
      Addr_Row    <= '0;
      Addr_Column <= '0;
      Data_input  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      pend_q    <= pend_d;
      run_q     <= run_d;
      we_q      <= we_d;
      REQ_READY <= (state_d == IDLE) && !must_ref(pend_d);
      ZQCL      <= state_d == ZQ;
      REF       <= state_d == REFRESH;
      ACT       <= state_d == XFER;
      WRITE     <= (state_d == XFER) && we_d;
      READ      <= (state_d == XFER) && !we_d;
      A_12      <= A_12 | (state_d == IDLE);
      if (accept) begin
        BA_in       <= REQ_ADDR[27:25];
        Addr_Row    <= REQ_ADDR[24:10];
        Addr_Column <= REQ_ADDR[9:0];
        A_10        <= REQ_AP;
        Data_input  <= REQ_WDATA;
      end
    end
  end
endmodule

// File: tb/tb_ddr3_req_scheduler.sv
// tb_ddr3_req_scheduler: directed self-checking bench for ddr3_req_scheduler (TREFI=20).
module tb_ddr3_req_scheduler;
  logic        CLK = 1'b0, RESET_N = 1'b0, REQ_VALID = 1'b0, REQ_WE = 1'b0, REQ_AP = 1'b0;
  logic [27:0] REQ_ADDR = '0;
  logic [15:0] REQ_WDATA = '0;
  logic        REQ_READY, ZQCL, REF, ACT, WRITE, READ, Addr_Column_11, A_12, A_10;
  logic [14:0] Addr_Row;
  logic [9:0]  Addr_Column;
  logic [1:0]  A13_14;
  logic [2:0]  BA_in;
  logic [15:0] Data_input;
  logic [3:0]  REF_PENDING;
  int checks = 0, fails = 0;
  ddr3_req_scheduler #(.INIT_CYCLES(16), .TXN_CYCLES(5), .TREFI(20), .TRFC_CYCLES(12)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_AP(REQ_AP), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .ZQCL(ZQCL), .REF(REF), .ACT(ACT), .WRITE(WRITE), .READ(READ),
    .Addr_Row(Addr_Row), .Addr_Column(Addr_Column), .Addr_Column_11(Addr_Column_11),
    .A_12(A_12), .A13_14(A13_14), .A_10(A_10), .BA_in(BA_in),
    .Data_input(Data_input), .REF_PENDING(REF_PENDING)
  );
  always #5 CLK = ~CLK;
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    RESET_N = 1'b0;
    REQ_VALID = 1'b0;
    step;
    step;
    checks++;
    if ({ZQCL, REF, ACT, WRITE, READ, REQ_READY, A_12} !== 7'b0) begin
      fails++;
      $display("FAIL reset_strobes got %b expected 0", {ZQCL, REF, ACT, WRITE, READ, REQ_READY, A_12});
    end
    checks++;
    if ({REF_PENDING, BA_in, Addr_Row, Addr_Column, A_10, Data_input, Addr_Column_11, A13_14} !== '0) begin
      fails++;
      $display("FAIL reset_fields got pend=%0d ba=%0d row=%h col=%h a10=%b data=%h", REF_PENDING, BA_in, Addr_Row, Addr_Column, A_10, Data_input);
    end
    #2 RESET_N = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step;
      checks++;
      if (ZQCL !== (k == 17)) begin
        fails++;
        $display("FAIL powerup_zqcl edge %0d got %b expected %b", k, ZQCL, k == 17);
      end
      checks++;
      if (REQ_READY !== (k == 20)) begin
        fails++;
        $display("FAIL powerup_ready edge %0d got %b expected %b", k, REQ_READY, k == 20);
      end
      checks++;
      if ({ACT, REF, WRITE, READ} !== 4'b0) begin
        fails++;
        $display("FAIL powerup_strobes edge %0d got %b expected 0000", k, {ACT, REF, WRITE, READ});
      end
      checks++;
      if (A_12 !== (k >= 20)) begin
        fails++;
        $display("FAIL powerup_a12 edge %0d got %b expected %b", k, A_12, k >= 20);
      end
    end
  endtask
  task automatic test_write;
    REQ_VALID = 1'b1;
    REQ_WE = 1'b1;
    REQ_AP = 1'b0;
    REQ_ADDR = 28'h2A0_0401;
    REQ_WDATA = 16'hBEEF;
    for (int k = 21; k <= 26; k++) begin
      step;
      if (k == 21) begin
        REQ_WE = 1'b0;
        REQ_AP = 1'b1;
        REQ_ADDR = 28'hC12_3456;
        REQ_WDATA = 16'h1234;
      end
      checks++;
      if ({ACT, WRITE, READ, REQ_READY} !== ((k < 26) ? 4'b1100 : 4'b0001)) begin
        fails++;
        $display("FAIL write_strobes edge %0d got act/wr/rd/rdy=%b expected %b", k, {ACT, WRITE, READ, REQ_READY}, (k < 26) ? 4'b1100 : 4'b0001);
      end
      checks++;
      if ({BA_in, Addr_Row, Addr_Column, Data_input, A_10, A_12} !== {3'd1, 15'h2801, 10'h001, 16'hBEEF, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL write_fields edge %0d got ba=%0d row=%h col=%h data=%h a10=%b a12=%b", k, BA_in, Addr_Row, Addr_Column, Data_input, A_10, A_12);
      end
    end
  endtask
  task automatic test_back_to_back;
    for (int k = 27; k <= 32; k++) begin
      step;
      if (k == 27) REQ_VALID = 1'b0;
      checks++;
      if ({ACT, WRITE, READ, REQ_READY} !== ((k < 32) ? 4'b1010 : 4'b0001)) begin
        fails++;
        $display("FAIL read_strobes edge %0d got act/wr/rd/rdy=%b expected %b", k, {ACT, WRITE, READ, REQ_READY}, (k < 32) ? 4'b1010 : 4'b0001);
      end
      checks++;
      if ({BA_in, Addr_Row, Addr_Column, A_10} !== {3'd6, 15'h048D, 10'h056, 1'b1}) begin
        fails++;
        $display("FAIL read_fields edge %0d got ba=%0d row=%h col=%h a10=%b", k, BA_in, Addr_Row, Addr_Column, A_10);
      end
    end
  endtask
  task automatic test_refresh_idle;
    for (int k = 33; k <= 100; k++) begin
      step;
      checks++;
      if (REF !== (k >= 41 && (k - 41) % 20 == 0)) begin
        fails++;
        $display("FAIL idle_ref edge %0d got %b expected %b", k, REF, k >= 41 && (k - 41) % 20 == 0);
      end
      checks++;
      if (REF_PENDING !== ((k >= 40 && (k - 40) % 20 == 0) ? 4'd1 : 4'd0)) begin
        fails++;
        $display("FAIL idle_pending edge %0d got %0d expected %0d", k, REF_PENDING, (k >= 40 && (k - 40) % 20 == 0) ? 1 : 0);
      end
      checks++;
      if (REQ_READY !== !(k >= 40 && (k - 40) % 20 < 14)) begin
        fails++;
        $display("FAIL idle_ready edge %0d got %b expected %b", k, REQ_READY, !(k >= 40 && (k - 40) % 20 < 14));
      end
      checks++;
      if (ACT !== 1'b0) begin
        fails++;
        $display("FAIL idle_act edge %0d got %b expected 0", k, ACT);
      end
    end
  endtask
  task automatic test_ref_act_gap;
    REQ_VALID = 1'b1;
    REQ_WE = 1'b1;
    for (int k = 101; k <= 115; k++) begin
      step;
      checks++;
      if ({REF, ACT, REQ_READY} !== {k == 101, k == 115, k == 114}) begin
        fails++;
        $display("FAIL gap edge %0d got ref/act/rdy=%b expected %b", k, {REF, ACT, REQ_READY}, {k == 101, k == 115, k == 114});
      end
    end
  endtask
  task automatic test_ref_priority;
    int refs = 0, maxp = 0, run = 0, maxrun = 0;
    for (int k = 116; k <= 315; k++) begin
      step;
      if (REF) refs++;
      if (int'(REF_PENDING) > maxp) maxp = int'(REF_PENDING);
      run = (REF_PENDING != 4'd0) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      checks++;
      if ((ACT && REF) || (READ && WRITE)) begin
        fails++;
        $display("FAIL exclusive edge %0d got act/ref/wr/rd=%b", k, {ACT, REF, WRITE, READ});
      end
    end
    checks++;
    if (refs != 10) begin
      fails++;
      $display("FAIL prio_ref_count got %0d expected 10", refs);
    end
    checks++;
    if (maxp > 1) begin
      fails++;
      $display("FAIL prio_max_pending got %0d expected <=1", maxp);
    end
    checks++;
    if (maxrun > 6) begin
      fails++;
      $display("FAIL prio_owed_cycles got %0d expected <=6", maxrun);
    end
  endtask
  task automatic test_ref_postpone;
    bit found = 0, early_ref = 0;
    REQ_VALID = 1'b1;
    REQ_WE = 1'b1;
    for (int i = 0; i < 400 && !found; i++) begin
      step;
      if (REF) early_ref = 1;
      if (REF_PENDING == 4'd8) found = 1;
    end
    checks++;
    if (!found || early_ref) begin
      fails++;
      $display("FAIL postpone_climb got reached8=%b early_ref=%b expected 1 0", found, early_ref);
    end
    checks++;
    if (REQ_READY !== 1'b0) begin
      fails++;
      $display("FAIL postpone_ready got %b expected 0", REQ_READY);
    end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step;
      if (REF) found = 1;
    end
    checks++;
    if (!found || REF_PENDING !== 4'd7) begin
      fails++;
      $display("FAIL postpone_forced_ref got ref=%b pend=%0d expected 1 7", found, REF_PENDING);
    end
    REQ_VALID = 1'b0;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      step;
      if (REF_PENDING == 4'd0) found = 1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL postpone_drain got pend=%0d expected 0", REF_PENDING);
    end
  endtask
  task automatic test_reset_mid_xfer;
    bit found = 0, prev = 0;
    REQ_VALID = 1'b1;
    REQ_WE = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      step;
      if (ACT && !prev) found = 1;
      prev = ACT;
    end
    step;
    step;
    checks++;
    if (!found || ACT !== 1'b1 || WRITE !== 1'b1) begin
      fails++;
      $display("FAIL midxfer_active got found=%b act=%b wr=%b expected 1 1 1", found, ACT, WRITE);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({ACT, WRITE, READ, REF, REQ_READY, REF_PENDING} !== 9'b0) begin
      fails++;
      $display("FAIL midxfer_async got act/wr/rd/ref/rdy=%b pend=%0d expected 0", {ACT, WRITE, READ, REF, REQ_READY}, REF_PENDING);
    end
    REQ_VALID = 1'b0;
    step;
    RESET_N = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step;
      checks++;
      if ({ZQCL, ACT, REQ_READY} !== {k == 17, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL restart edge %0d got zq/act/rdy=%b expected %b", k, {ZQCL, ACT, REQ_READY}, {k == 17, 1'b0, 1'b0});
      end
    end
  endtask
  initial begin
    test_reset;
    test_write;
    test_back_to_back;
    test_refresh_idle;
`ifdef REF_POSTPONE_EN
    test_ref_postpone;
`else
    test_ref_act_gap;
    test_ref_priority;
`endif
    test_reset_mid_xfer;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
